// File: rtl/ahb_fifo_arb_pkg.sv
// Shared definitions for the ahb_fifo_wr_arb write arbiter:
// - FSM state encoding.
// - Round-robin pick function.
// - Watchdog counter width.
package ahb_fifo_arb_pkg;

    // Legacy-compatible state encoding
    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_BUSY = 1'b1;

    // The pick function works on a fixed 8-bit vector, which covers NREQ up to 8
    localparam int RR_MAX_REQ = 8;

    // Default watchdog stall limit and the counter width it needs
    localparam int WDOG_IDLE_MAX_DEF = 15;
    localparam int WDOG_CNT_W        = $clog2(WDOG_IDLE_MAX_DEF + 1);

    // One-hot winner of a round-robin search over req[nreq-1:0].
    // The search starts at ptr and wraps modulo nreq.
    // Returns zero when nothing is requesting.
    function automatic logic [RR_MAX_REQ-1:0] rr_pick(
        input logic [RR_MAX_REQ-1:0] req,
        input logic [2:0]            ptr,
        input int                    nreq
    );
        logic [RR_MAX_REQ-1:0] win;
        logic                  found;
        logic [2:0]            idx;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < RR_MAX_REQ; i++) begin
            idx = 3'((int'(ptr) + i) % nreq);
            if ((i < nreq) && !found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_arb_core.sv
// Purely combinational round-robin picker.
// Maps (req, ptr) to (valid, idx, onehot).
// The top level shares one instance between the idle pick and the end-of-packet pick.
module rr_arb_core
    import ahb_fifo_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o,
    output logic [NREQ-1:0]  onehot_o
);

    logic [RR_MAX_REQ-1:0] pick;
    logic                  unused_pick;

    // Widen to the function's fixed width, then take back the live bits
    always_comb begin
        pick = rr_pick(RR_MAX_REQ'(req_i), 3'(ptr_i), NREQ);
    end

    assign onehot_o    = pick[NREQ-1:0];
    assign valid_o     = |onehot_o;
    assign unused_pick = ^pick;

    // One-hot to index encode
    always_comb begin
        idx_o = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (onehot_o[k]) idx_o = IDX_W'(k);
        end
    end

endmodule

// File: rtl/ahb_fifo_wr_arb.sv
// Packet-based round-robin arbiter that shares one sync_fifo write port
// among NREQ requesters.
// - A requester keeps the grant until a beat flagged last is accepted.
// - Beats are accepted with zero latency from the registered grant.
// - Optional stall watchdog is enabled by defining AHB_FIFO_WR_ARB_WDOG_EN.
//
// state      | meaning
// -----------+----------------------------------------------
// STATE_IDLE | no owner; searching from rr_ptr_q
// STATE_BUSY | owner held in own_q / gnt_q; beats pass through
module ahb_fifo_wr_arb
    import ahb_fifo_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DATA_W   = 36,
    parameter int IDLE_MAX = WDOG_IDLE_MAX_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_i,
    input  logic [NREQ-1:0]        last_i,
    input  logic [NREQ*DATA_W-1:0] data_i,
    output logic [NREQ-1:0]        ack_o,
    output logic [NREQ-1:0]        gnt_o,
    output logic                   wfifo_o,
    output logic [DATA_W-1:0]      wdata_o,
    input  logic                   wfull_i,
    output logic                   err_o
);

    localparam int IDX_W = $clog2(NREQ);

    logic             state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0] own_q, own_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    logic             busy;
    logic             own_req;
    logic             own_last;
    logic             accept;
    logic             wdog_fire;
    logic             release_pkt;
    logic [IDX_W-1:0] next_ptr;
    logic [IDX_W-1:0] arb_ptr;
    logic [NREQ-1:0]  arb_req;
    logic             arb_valid;
    logic [IDX_W-1:0] arb_idx;
    logic [NREQ-1:0]  arb_onehot;
    logic [DATA_W-1:0] sel_data;

    assign busy     = (state_q == STATE_BUSY);
    assign own_req  = req_i[own_q];
    assign own_last = last_i[own_q];
    assign accept   = busy & own_req & ~wfull_i;
    assign next_ptr = (own_q == IDX_W'(NREQ - 1)) ? '0 : own_q + 1'b1;

    // At packet end the finishing owner is excluded from the re-pick.
    // Its request in that cycle is the last beat, not a new packet.
    assign arb_ptr = busy ? next_ptr : rr_ptr_q;
    assign arb_req = busy ? (req_i & ~gnt_q) : req_i;

    rr_arb_core #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_arb_core (
        .req_i    (arb_req),
        .ptr_i    (arb_ptr),
        .valid_o  (arb_valid),
        .idx_o    (arb_idx),
        .onehot_o (arb_onehot)
    );

`ifdef AHB_FIFO_WR_ARB_WDOG_EN
    // Never narrower than the width needed for the default limit
    localparam int CNT_W = (WDOG_CNT_W > $clog2(IDLE_MAX + 1)) ?
                           WDOG_CNT_W : $clog2(IDLE_MAX + 1);

    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

    // Fires on the IDLE_MAX-th consecutive owner bubble
    assign wdog_fire = busy & ~own_req & (idle_cnt_q == CNT_W'(IDLE_MAX - 1));
    assign err_o     = wdog_fire;

    // Count consecutive owner bubbles.
    // Any owner request clears the count, including one stalled by wfull_i.
    always_comb begin
        idle_cnt_d = '0;
        if (busy && !own_req && !wdog_fire) idle_cnt_d = idle_cnt_q + 1'b1;
    end

    // Bubble counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idle_cnt_q <= '0;
        else        idle_cnt_q <= idle_cnt_d;
    end
`else
    localparam int unused_idle_max = IDLE_MAX;

    assign wdog_fire = 1'b0;
    assign err_o     = 1'b0;
`endif

    assign release_pkt = (accept & own_last) | wdog_fire;

    // Owner's data word
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (own_q == IDX_W'(k)) sel_data = data_i[k*DATA_W +: DATA_W];
        end
    end

    assign ack_o   = accept ? gnt_q : '0;
    assign gnt_o   = gnt_q;
    assign wfifo_o = accept;
    assign wdata_o = accept ? sel_data : '0;

    // Grant / pointer next-state.
    // Packet end hands over directly to the next requester when one is waiting.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        own_d    = own_q;
        rr_ptr_d = rr_ptr_q;
        if (!busy) begin
            if (arb_valid) begin
                state_d = STATE_BUSY;
                gnt_d   = arb_onehot;
                own_d   = arb_idx;
            end
        end else if (release_pkt) begin
            rr_ptr_d = next_ptr;
            if (arb_valid) begin
                gnt_d = arb_onehot;
                own_d = arb_idx;
            end else begin
                state_d = STATE_IDLE;
                gnt_d   = '0;
                own_d   = '0;
            end
        end
    end

    // State, grant and round-robin pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= STATE_IDLE;
            gnt_q    <= '0;
            own_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            own_q    <= own_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_ahb_fifo_wr_arb.sv
// Self-checking bench for ahb_fifo_wr_arb (NREQ=4, DATA_W=36, IDLE_MAX=15).
// Watchdog expectations follow AHB_FIFO_WR_ARB_WDOG_EN.
module tb_ahb_fifo_wr_arb;

    localparam int NREQ     = 4;
    localparam int DATA_W   = 36;
    localparam int IDLE_MAX = 15;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        req_i, last_i, ack_o, gnt_o;
    logic [NREQ*DATA_W-1:0] data_i;
    logic                   wfifo_o, wfull_i, err_o;
    logic [DATA_W-1:0]      wdata_o;

    int n_cmp = 0;
    int n_err = 0;

`ifdef AHB_FIFO_WR_ARB_WDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    ahb_fifo_wr_arb #(
        .NREQ     (NREQ),
        .DATA_W   (DATA_W),
        .IDLE_MAX (IDLE_MAX)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (req_i),
        .last_i  (last_i),
        .data_i  (data_i),
        .ack_o   (ack_o),
        .gnt_o   (gnt_o),
        .wfifo_o (wfifo_o),
        .wdata_o (wdata_o),
        .wfull_i (wfull_i),
        .err_o   (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner, busy flag, round-robin pointer, bubble run length
    int m_busy, m_own, m_ptr, m_idle;

    task automatic do_reset();
        rst_n   = 1'b0;
        req_i   = '0;
        last_i  = '0;
        wfull_i = 1'b0;
        data_i  = '0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", gnt_o, 0);
        chk("rst_ack", ack_o, 0);
        chk("rst_wfifo", wfifo_o, 0);
        chk("rst_err", err_o, 0);
        rst_n  = 1'b1;
        m_busy = 0;
        m_own  = 0;
        m_ptr  = 0;
        m_idle = 0;
    endtask

    task automatic set_tag(input int tag);
        for (int k = 0; k < NREQ; k++) data_i[k*DATA_W +: DATA_W] = DATA_W'(tag * 16 + k);
    endtask

    // One cycle of the reference model, evaluated on the driven inputs
    task automatic model_cycle();
        logic [NREQ-1:0] e_gnt, e_ack;
        bit              acc, e_err, rel;
        int              c;
        e_gnt = m_busy ? NREQ'(1 << m_own) : '0;
        acc   = m_busy && req_i[m_own] && !wfull_i;
        e_ack = acc ? e_gnt : '0;
        e_err = WDOG && m_busy && !req_i[m_own] && (m_idle + 1 == IDLE_MAX);
        chk("rnd_gnt", gnt_o, e_gnt);
        chk("rnd_ack", ack_o, e_ack);
        chk("rnd_wfifo", wfifo_o, acc);
        chk("rnd_err", err_o, e_err);
        if (acc) chk("rnd_wdata", wdata_o, data_i[m_own*DATA_W +: DATA_W]);
        rel = (acc && last_i[m_own]) || e_err;
        if (m_busy && !req_i[m_own]) m_idle++;
        else                         m_idle = 0;
        if (m_busy == 0) begin
            for (int k = 0; k < NREQ; k++) begin
                c = (m_ptr + k) % NREQ;
                if (req_i[c]) begin
                    m_busy = 1;
                    m_own  = c;
                    break;
                end
            end
        end else if (rel) begin
            m_ptr  = (m_own + 1) % NREQ;
            m_busy = 0;
            m_idle = 0;
            for (int k = 0; k < NREQ - 1; k++) begin
                c = (m_ptr + k) % NREQ;
                if (req_i[c]) begin
                    m_busy = 1;
                    m_own  = c;
                    break;
                end
            end
        end
    endtask

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] last;
        logic       full;
        logic [3:0] gnt;
        logic [3:0] ack;
    } vec_t;

    vec_t tbl [22];

    initial begin
        logic [DATA_W-1:0] got [$];
        logic [63:0]       rd;
        int                idx, fcnt, pushed, viol, cyc, pct;

        rst_n   = 1'b0;
        req_i   = '0;
        last_i  = '0;
        wfull_i = 1'b0;
        data_i  = '0;

        //            req      last     full  gnt      ack
        tbl[0]  = '{4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b0001};
        tbl[2]  = '{4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b0001};
        tbl[3]  = '{4'b0001, 4'b0001, 1'b0, 4'b0001, 4'b0001};
        tbl[4]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000};
        tbl[5]  = '{4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b0000};
        tbl[6]  = '{4'b1111, 4'b0000, 1'b0, 4'b0010, 4'b0010};
        tbl[7]  = '{4'b1111, 4'b0010, 1'b0, 4'b0010, 4'b0010};
        tbl[8]  = '{4'b1111, 4'b0000, 1'b0, 4'b0100, 4'b0100};
        tbl[9]  = '{4'b1111, 4'b0100, 1'b0, 4'b0100, 4'b0100};
        tbl[10] = '{4'b1111, 4'b0000, 1'b0, 4'b1000, 4'b1000};
        tbl[11] = '{4'b1111, 4'b1000, 1'b0, 4'b1000, 4'b1000};
        tbl[12] = '{4'b1111, 4'b0000, 1'b0, 4'b0001, 4'b0001};
        tbl[13] = '{4'b1111, 4'b0001, 1'b0, 4'b0001, 4'b0001};
        tbl[14] = '{4'b1111, 4'b0010, 1'b1, 4'b0010, 4'b0000};
        tbl[15] = '{4'b1111, 4'b0010, 1'b0, 4'b0010, 4'b0010};
        tbl[16] = '{4'b1000, 4'b0000, 1'b0, 4'b0100, 4'b0000};
        tbl[17] = '{4'b1000, 4'b0000, 1'b0, 4'b0100, 4'b0000};
        tbl[18] = '{4'b1100, 4'b0100, 1'b0, 4'b0100, 4'b0100};
        tbl[19] = '{4'b0000, 4'b0000, 1'b0, 4'b1000, 4'b0000};
        tbl[20] = '{4'b1000, 4'b1000, 1'b0, 4'b1000, 4'b1000};
        tbl[21] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000};

        // Table vectors: single requester, fairness, stall on last, bubble hold
        do_reset();
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            req_i   = tbl[i].req;
            last_i  = tbl[i].last;
            wfull_i = tbl[i].full;
            set_tag(i);
            #1;
            chk("tbl_gnt", gnt_o, tbl[i].gnt);
            chk("tbl_ack", ack_o, tbl[i].ack);
            chk("tbl_wfifo", wfifo_o, |tbl[i].ack);
            chk("tbl_err", err_o, 0);
            if (tbl[i].ack != 0) begin
                idx = 0;
                for (int k = 0; k < NREQ; k++) if (tbl[i].ack[k]) idx = k;
                chk("tbl_wdata", wdata_o, DATA_W'(i * 16 + idx));
            end
        end

        // Backpressure: 8-deep FIFO holding 7, reader pops every 4th cycle
        do_reset();
        fcnt   = 7;
        pushed = 0;
        viol   = 0;
        cyc    = 0;
        got.delete();
        while (pushed < 3 && cyc < 60) begin
            @(negedge clk);
            req_i   = 4'b0100;
            last_i  = (pushed == 2) ? 4'b0100 : 4'b0000;
            wfull_i = (fcnt >= 8);
            data_i  = '0;
            data_i[2*DATA_W +: DATA_W] = DATA_W'(36'hA00 + pushed);
            #1;
            if (wfifo_o && wfull_i) viol++;
            chk("bp_gnt", gnt_o, (cyc == 0) ? 4'b0000 : 4'b0100);
            chk("bp_ack", ack_o, (cyc >= 1 && !wfull_i) ? 4'b0100 : 4'b0000);
            if (wfifo_o) begin
                got.push_back(wdata_o);
                pushed++;
                fcnt++;
            end
            if (cyc % 4 == 3 && fcnt > 0) fcnt--;
            cyc++;
        end
        chk("bp_beats", pushed, 3);
        chk("bp_overflow", viol, 0);
        for (int i = 0; i < 3; i++) begin
            if (i < got.size()) chk("bp_data", got[i], 36'hA00 + i);
        end
        @(negedge clk);
        req_i   = '0;
        last_i  = '0;
        wfull_i = 1'b0;
        #1;
        chk("bp_release", gnt_o, 0);

        // Watchdog: owner 0 bubbles for IDLE_MAX cycles while requester 1 waits
        do_reset();
        set_tag(5);
        @(negedge clk);
        req_i = 4'b0001;
        #1;
        chk("wd_arb", gnt_o, 0);
        @(negedge clk);
        req_i = 4'b0011;
        #1;
        chk("wd_beat", ack_o, 4'b0001);
        for (int i = 1; i <= IDLE_MAX; i++) begin
            @(negedge clk);
            req_i = 4'b0010;
            #1;
            chk("wd_hold", gnt_o, 4'b0001);
            chk("wd_noack", ack_o, 0);
            chk("wd_err", err_o, WDOG && (i == IDLE_MAX));
        end
        @(negedge clk);
        req_i = 4'b0010;
        #1;
        chk("wd_after_gnt", gnt_o, WDOG ? 4'b0010 : 4'b0001);
        chk("wd_after_ack", ack_o, WDOG ? 4'b0010 : 4'b0000);
        chk("wd_after_err", err_o, 0);

        // Reset mid-packet, then confirm the pointer restarts at 0
        do_reset();
        set_tag(7);
        @(negedge clk);
        req_i = 4'b0010;
        @(negedge clk);
        req_i  = 4'b0010;
        last_i = 4'b0010;
        #1;
        chk("rm_pkt1", ack_o, 4'b0010);
        @(negedge clk);
        req_i  = 4'b0100;
        last_i = 4'b0000;
        @(negedge clk);
        #1;
        chk("rm_beat1", ack_o, 4'b0100);
        @(negedge clk);
        #1;
        chk("rm_beat2", wfifo_o, 1);
        rst_n = 1'b0;
        #1;
        chk("rm_async_gnt", gnt_o, 0);
        chk("rm_async_wfifo", wfifo_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        req_i = 4'b1111;
        #1;
        chk("rm_idle", gnt_o, 0);
        @(negedge clk);
        #1;
        chk("rm_ptr0", gnt_o, 4'b0001);

        // Randomized traffic: dense, then sparse requests
        for (int phase = 0; phase < 2; phase++) begin
            do_reset();
            pct = (phase == 0) ? 70 : 20;
            for (int n = 0; n < 3000; n++) begin
                @(negedge clk);
                for (int k = 0; k < NREQ; k++) begin
                    req_i[k]  = ($urandom_range(0, 99) < pct);
                    last_i[k] = ($urandom_range(0, 3) == 0);
                    rd = {$urandom(), $urandom()};
                    data_i[k*DATA_W +: DATA_W] = rd[DATA_W-1:0];
                end
                wfull_i = ($urandom_range(0, 4) == 0);
                #1;
                model_cycle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
